// File: rtl/dmux_channel_sequencer.sv
// Registered select/data driver for a 1:8 demux: accepts single requests or auto-scans channels 0..7.
// Define DMUX_SEQ_GAP_EN to insert a one-cycle break-before-make GAP after every dwell.
module dmux_channel_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_dest,
    input  logic       req_data,
    input  logic       scan_en,
    input  logic       scan_data,
    output logic [2:0] s,
    output logic       i,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2:0]         scan_ptr_reg;
    logic               is_scan_reg;
    logic [2:0]         s_reg;
    logic               i_reg;
    logic               busy_reg;
    logic               done_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            scan_ptr_reg <= 3'd0;
            is_scan_reg  <= 1'b0;
            s_reg        <= 3'd0;
            i_reg        <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    i_reg <= 1'b0;
                    // An explicit request wins over the scan; the scan pointer only moves on scan dwells.
                    if (req_valid) begin
                        s_reg       <= req_dest;
                        i_reg       <= req_data;
                        cnt_reg     <= HOLD_LAST;
                        is_scan_reg <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= DRIVE;
                    end else if (scan_en) begin
                        s_reg       <= scan_ptr_reg;
                        i_reg       <= scan_data;
                        cnt_reg     <= HOLD_LAST;
                        is_scan_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt_reg == '0) begin
                        i_reg    <= 1'b0;
                        done_reg <= 1'b1;
                        if (is_scan_reg) begin
                            scan_ptr_reg <= scan_ptr_reg + 3'd1;
                        end
`ifdef DMUX_SEQ_GAP_EN
                        state_reg <= GAP;
                        busy_reg  <= 1'b1;
`else
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
`endif
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
`ifdef DMUX_SEQ_GAP_EN
                GAP: begin
                    // s stays put for one extra cycle with i low so the old output never glitches.
                    i_reg     <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
`endif
                default: begin
                    i_reg     <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_reg == IDLE) & ~rst;
    assign s         = s_reg;
    assign i         = i_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_dmux_channel_sequencer.sv
// Self-checking bench for dmux_channel_sequencer (HOLD_CYCLES=4 main instance, HOLD_CYCLES=1 second instance).
// Expected timing adapts to whether DMUX_SEQ_GAP_EN is defined.
module tb_dmux_channel_sequencer;

    localparam int H = 4;
`ifdef DMUX_SEQ_GAP_EN
    localparam int G = 1;
`else
    localparam int G = 0;
`endif
    localparam int P  = H + 1 + G;   // cycles per selection, main instance
    localparam int P1 = 1 + 1 + G;   // cycles per selection, HOLD_CYCLES=1 instance

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0, req_data = 1'b0, scan_en = 1'b0, scan_data = 1'b0;
    logic [2:0] req_dest = 3'd0;
    logic       req_ready, i, busy, done;
    logic [2:0] s;

    logic       r1_valid = 1'b0, r1_data = 1'b0, scan1_en = 1'b0, scan1_data = 1'b0;
    logic [2:0] r1_dest = 3'd0;
    logic       r1_ready, i1, busy1, done1;
    logic [2:0] s1;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    dmux_channel_sequencer #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_dest(req_dest), .req_data(req_data), .scan_en(scan_en), .scan_data(scan_data),
        .s(s), .i(i), .busy(busy), .done(done)
    );

    dmux_channel_sequencer #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .req_valid(r1_valid), .req_ready(r1_ready),
        .req_dest(r1_dest), .req_data(r1_data), .scan_en(scan1_en), .scan_data(scan1_data),
        .s(s1), .i(i1), .busy(busy1), .done(done1)
    );

    // Reference model for random traffic: one queue entry per busy cycle of the main instance.
    typedef struct packed {
        logic [2:0] s;
        logic       i;
        logic       done;
        logic       last;
    } ent_t;

    ent_t       mq[$];
    logic [2:0] m_last_s;
    logic       m_idle_done;
    int         m_ptr;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic model_push(input logic [2:0] d, input logic x);
        ent_t e;
        m_last_s = d;
        for (int k = 0; k < H + G; k++) begin
            e.s    = d;
            e.i    = (k < H) ? x : 1'b0;
            e.done = (k >= H);
            e.last = (k == H + G - 1);
            mq.push_back(e);
        end
    endtask

    task automatic test_reset();
        req_valid = 1'($urandom); req_dest = 3'($urandom); req_data = 1'($urandom);
        scan_en = 1'($urandom); scan_data = 1'($urandom);
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (s !== 3'd0 || i !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b0) begin
                fails++;
                $display("FAIL reset_state: s=%0d i=%b busy=%b done=%b req_ready=%b, required 0 0 0 0 0",
                         s, i, busy, done, req_ready);
            end
        end
        req_valid = 1'b0; scan_en = 1'b0; rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || r1_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: req_ready=%b r1_ready=%b, required 1 1", req_ready, r1_ready);
        end
        $display("reset: outputs cleared, req_ready=%b after release", req_ready);
    endtask

    task automatic test_single();
        req_valid = 1'b1; req_dest = 3'd5; req_data = 1'b1;
        tick();
        req_valid = 1'b0; req_dest = 3'd0; req_data = 1'b0;
        for (int k = 0; k < H; k++) begin
            checks++;
            if (s !== 3'd5 || i !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL single_drive[%0d]: s=%0d i=%b busy=%b done=%b, required 5 1 1 0", k, s, i, busy, done);
            end
            tick();
        end
        checks++;
        if (s !== 3'd5 || i !== 1'b0 || done !== 1'b1 || busy !== (G == 1)) begin
            fails++;
            $display("FAIL single_done: s=%0d i=%b done=%b busy=%b, required 5 0 1 %b", s, i, done, busy, G == 1);
        end
        repeat (G) tick();
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || i !== 1'b0 || done !== (G == 0)) begin
            fails++;
            $display("FAIL single_idle: busy=%b req_ready=%b i=%b done=%b, required 0 1 0 %b",
                     busy, req_ready, i, done, G == 0);
        end
        $display("single: dest=5 data=1 dwell of %0d cycles completed", H);
    endtask

    task automatic test_scan_wrap();
        int n, ph, dones;
        do_reset();
        dones = 0;
        scan_en = 1'b1; scan_data = 1'b1;
        for (int t = 1; t <= 9 * P; t++) begin
            tick();
            n  = (t - 1) / P;
            ph = (t - 1) % P;
            checks++;
            if (s !== 3'(n % 8) || i !== (ph < H) || done !== (ph == H)) begin
                fails++;
                $display("FAIL scan_wrap t=%0d: s=%0d i=%b done=%b, required %0d %b %b",
                         t, s, i, done, n % 8, ph < H, ph == H);
            end
            if (t <= 8 * P && done === 1'b1) dones++;
        end
        scan_en = 1'b0;
        checks++;
        if (dones != 8) begin
            fails++;
            $display("FAIL scan_done_count: counted %0d, required 8", dones);
        end
        $display("scan_wrap: 9 dwells, %0d done pulses in first 8", dones);
    endtask

    task automatic test_collision();
        do_reset();
        scan_en = 1'b1; scan_data = 1'b1;
        repeat (6 * P) tick();
        scan_en = 1'b0;
        req_valid = 1'b1; req_dest = 3'd2; req_data = 1'b1;
        scan_en = 1'b1; scan_data = 1'b0;
        for (int t = 1; t <= 2 * P; t++) begin
            tick();
            req_valid = 1'b0;
            checks++;
            if (t <= P) begin
                if (s !== 3'd2 || i !== ((t - 1) < H)) begin
                    fails++;
                    $display("FAIL collision_req t=%0d: s=%0d i=%b, required 2 %b", t, s, i, (t - 1) < H);
                end
            end else begin
                if (s !== 3'd6 || i !== 1'b0) begin
                    fails++;
                    $display("FAIL collision_scan t=%0d: s=%0d i=%b, required 6 0", t, s, i);
                end
            end
        end
        scan_data = 1'b1;
        tick();
        scan_en = 1'b0;
        checks++;
        if (s !== 3'd7 || i !== 1'b1) begin
            fails++;
            $display("FAIL collision_next_scan: s=%0d i=%b, required 7 1", s, i);
        end
        repeat (P - 1) tick();
        $display("collision: request to 2 served before scan channel 6");
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_dest = 3'd3; req_data = 1'b1;
        tick();
        req_dest = 3'd7; req_data = 1'b0;
        for (int t = 1; t <= P; t++) begin
            if (t > 1) tick();
            checks++;
            if (s !== 3'd3 || i !== (t <= H) || req_ready !== (t == P)) begin
                fails++;
                $display("FAIL backpressure t=%0d: s=%0d i=%b req_ready=%b, required 3 %b %b",
                         t, s, i, req_ready, t <= H, t == P);
            end
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (s !== 3'd7 || i !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_accept: s=%0d i=%b busy=%b, required 7 0 1", s, i, busy);
        end
        for (int t = P + 2; t <= 2 * P; t++) begin
            req_dest = 3'($urandom); req_data = 1'b1;
            tick();
            checks++;
            if (s !== 3'd7 || i !== 1'b0) begin
                fails++;
                $display("FAIL sampled_once t=%0d: s=%0d i=%b, required 7 0", t, s, i);
            end
        end
        $display("back_to_back: held request accepted at first idle cycle");
    endtask

    task automatic test_reset_abort();
        req_valid = 1'b1; req_dest = 3'd4; req_data = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        checks++;
        if (s !== 3'd4 || i !== 1'b1) begin
            fails++;
            $display("FAIL abort_mid_drive: s=%0d i=%b, required 4 1", s, i);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            fails++;
            $display("FAIL abort_ready: req_ready=%b, required 0", req_ready);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (i !== 1'b0 || s !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_state: s=%0d i=%b busy=%b done=%b, required 0 0 0 0", s, i, busy, done);
        end
        for (int c = 0; c < H + 2; c++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL abort_no_done c=%0d: done=%b busy=%b, required 0 0", c, done, busy);
            end
        end
        $display("reset_abort: dwell aborted without done pulse");
    endtask

    task automatic test_hold_one();
        localparam int N = 12;
        logic [2:0] d[N + 1];
        int accepts, n, ph;
        accepts = 0;
        for (int k = 0; k <= N; k++) d[k] = 3'($urandom);
        r1_valid = 1'b1; r1_data = 1'b1;
        for (int t = 0; t < N * P1; t++) begin
            r1_dest = d[t / P1];
            #1;
            checks++;
            if (r1_ready !== (t % P1 == 0)) begin
                fails++;
                $display("FAIL hold1_ready t=%0d: r1_ready=%b, required %b", t, r1_ready, t % P1 == 0);
            end
            if (r1_ready === 1'b1) accepts++;
            tick();
            n  = t / P1;
            ph = t % P1;
            checks++;
            if (s1 !== d[n] || i1 !== (ph == 0) || done1 !== (ph == 1)) begin
                fails++;
                $display("FAIL hold1 t=%0d: s=%0d i=%b done=%b, required %0d %b %b",
                         t, s1, i1, done1, d[n], ph == 0, ph == 1);
            end
        end
        r1_valid = 1'b0;
        checks++;
        if (accepts != N) begin
            fails++;
            $display("FAIL hold1_accepts: counted %0d, required %0d", accepts, N);
        end
        $display("hold_one: %0d requests in %0d cycles", accepts, N * P1);
    endtask

    task automatic test_random();
        ent_t e;
        logic [2:0] es;
        logic ei, eb, ed;
        do_reset();
        mq.delete();
        m_last_s = 3'd0; m_idle_done = 1'b0; m_ptr = 0;
        for (int c = 0; c < 400; c++) begin
            if (mq.size() > 0) begin
                es = mq[0].s; ei = mq[0].i; eb = 1'b1; ed = mq[0].done;
            end else begin
                es = m_last_s; ei = 1'b0; eb = 1'b0; ed = m_idle_done;
            end
            checks++;
            if (s !== es || i !== ei || busy !== eb || done !== ed) begin
                fails++;
                $display("FAIL random c=%0d: s=%0d i=%b busy=%b done=%b, required %0d %b %b %b",
                         c, s, i, busy, done, es, ei, eb, ed);
            end
            rst       = ($urandom_range(0, 39) == 0);
            req_valid = 1'($urandom);
            req_dest  = 3'($urandom);
            req_data  = 1'($urandom);
            scan_en   = 1'($urandom);
            scan_data = 1'($urandom);
            #1;
            checks++;
            if (req_ready !== (mq.size() == 0 && !rst)) begin
                fails++;
                $display("FAIL random_ready c=%0d: req_ready=%b, required %b", c, req_ready, mq.size() == 0 && !rst);
            end
            if (rst) begin
                mq.delete();
                m_last_s = 3'd0; m_idle_done = 1'b0; m_ptr = 0;
            end else if (mq.size() == 0) begin
                m_idle_done = 1'b0;
                if (req_valid) begin
                    model_push(req_dest, req_data);
                end else if (scan_en) begin
                    model_push(3'(m_ptr), scan_data);
                    m_ptr = (m_ptr + 1) % 8;
                end
            end else begin
                e = mq.pop_front();
                m_idle_done = e.last && (G == 0);
            end
            tick();
        end
        rst = 1'b0; req_valid = 1'b0; scan_en = 1'b0;
        $display("random: 400 cycles compared against model");
    endtask

    initial begin
        tick();
        test_reset();
        test_single();
        test_scan_wrap();
        test_collision();
        test_back_to_back();
        test_reset_abort();
        test_hold_one();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
